psram_clk_reset_seq: RTL and testbench
======================================

Name: psram_clk_reset_seq

Overview:
- Sits directly downstream of the PLL wrapper and runs in the 81 MHz PLL output domain.
- Synchronises and qualifies the PLL lock indication.
- Holds the PSRAM controller in reset until the clock is stable.
- Enforces the PSRAM 150 us power-up wait, then runs a request/acknowledge handshake so the controller can issue its init sequence. Raises ready when done.
- Any later loss of lock restarts the whole sequence.

Parameters:
- FREQ_HZ, 81000000, clk frequency; used to derive power-up cycles.
- POWERUP_US, 150, power-up wait in microseconds; POWERUP_CYCLES = (FREQ_HZ/1000000)*POWERUP_US, which is 12150 at the defaults.
- LOCK_STABLE, 1024, consecutive cycles synchronised lock must be high before it is trusted.
- SYNC_STAGES, 2, flop stages on pll_lock (minimum 2).
- INIT_TIMEOUT, 4096, maximum cycles in INIT waiting for init_ack.

Ports:
- clk  input  1  PLL output clock (clkout, 81 MHz)
- rst  input  1  asynchronous, active-high reset
- pll_lock  input  1  PLL LOCK; asynchronous to clk
- init_ack  input  1  controller pulse or level: init sequence complete
- ctrl_reset  output  1  active-high reset to PSRAM controller
- init_req  output  1  request controller to run PSRAM init
- ready  output  1  memory subsystem usable
- fault  output  1  init timed out
- state  output  3  current state encoding, for debug

Behaviour:
- Reset:
  - rst asserted: all sync flops 0, counter 0, state=WAIT_LOCK.
  - Outputs during rst: ctrl_reset=1, init_req=0, ready=0, fault=0, state=0.
- Lock synchroniser: lock_s = pll_lock delayed through SYNC_STAGES flops. No other use of the raw pll_lock.
- State encodings: WAIT_LOCK=0, LOCK_QUAL=1, POWERUP=2, INIT=3, READY=4, FAULT=5. All outputs are decoded from the state register (registered, glitch-free).
- Transitions (one per rising edge):
  - WAIT_LOCK: if lock_s=1, go to LOCK_QUAL; counter=0.
  - LOCK_QUAL: if lock_s=0, go to WAIT_LOCK. Else if counter==LOCK_STABLE-1, go to POWERUP with counter=0. Else counter+1.
  - POWERUP: if counter==POWERUP_CYCLES-1, go to INIT with counter=0. Else counter+1.
  - INIT: if init_ack=1, go to READY. Else if counter==INIT_TIMEOUT-1, go to FAULT. Else counter+1. If ack and timeout occur on the same edge, ack wins (READY).
  - READY: hold.
  - FAULT: hold. Leaves only on rst or loss of lock.
- Lock loss:
  - In any state other than WAIT_LOCK, lock_s=0 forces WAIT_LOCK on that edge, with counter=0.
  - Lock loss has priority over every other transition, including init_ack.
- Output decode:
  - ctrl_reset=1 in WAIT_LOCK and LOCK_QUAL; 0 otherwise.
  - init_req=1 only in INIT.
  - ready=1 only in READY.
  - fault=1 only in FAULT.
- Latency, counting the first edge that samples pll_lock=1 as edge 0 with lock held high:
  - ctrl_reset falls after edge SYNC_STAGES+LOCK_STABLE.
  - init_req rises POWERUP_CYCLES edges after that.
  - ready rises on the edge that samples init_ack=1 while in INIT; init_req falls on the same edge.
- Widths: a single shared counter of width clog2(max(LOCK_STABLE, POWERUP_CYCLES, INIT_TIMEOUT)). The counter never wraps, because every state exits at its terminal count.
- A pll_lock glitch shorter than LOCK_STABLE during LOCK_QUAL restarts qualification from zero.
- init_ack outside INIT is ignored.

Test Plan:
- Nominal sequence. Override LOCK_STABLE=16, POWERUP_US=2 (162 cycles), SYNC_STAGES=2. Raise pll_lock at edge 0 and hold it.
  - Required: ctrl_reset falls after edge 18 and init_req rises after edge 180.
  - Ack at edge 190: ready=1 and init_req=0 after edge 190; state=4.
- Lock glitch: drop pll_lock for 3 cycles at edge 10 of the nominal run. Required: state returns to 0, ctrl_reset stays 1, and qualification restarts. ctrl_reset falls 18 edges after lock re-rises.
- Init timeout: override INIT_TIMEOUT=8 and never ack. Required: fault=1 exactly 8 edges after init_req rises; init_req=0; ready=0.
- Ack/timeout collision: with INIT_TIMEOUT=8, assert init_ack on the 8th INIT edge. Required: ready=1, fault=0.
- Lock loss in READY: deassert pll_lock. Required: ready falls and ctrl_reset rises 3 edges later (SYNC_STAGES+1). Re-locking repeats the full sequence.
- Async reset mid-POWERUP: pulse rst between clock edges. Required: ctrl_reset=1 and state=0 immediately, without waiting for a clock edge. After release, the sequence restarts from WAIT_LOCK.

Source files
------------

// File: rtl/psram_clk_reset_seq.sv
// Clock/reset sequencer for the PSRAM controller: qualifies PLL lock, holds the
// controller in reset, waits out PSRAM power-up, then handshakes the init sequence.
module psram_clk_reset_seq #(
  parameter int FREQ_HZ      = 81000000,
  parameter int POWERUP_US   = 150,
  parameter int LOCK_STABLE  = 1024,
  parameter int SYNC_STAGES  = 2,
  parameter int INIT_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       init_ack,
  output logic       ctrl_reset,
  output logic       init_req,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state
);

  localparam int POWERUP_CYCLES = (FREQ_HZ / 1000000) * POWERUP_US;
  localparam int MAX_LP  = (LOCK_STABLE > POWERUP_CYCLES) ? LOCK_STABLE : POWERUP_CYCLES;
  localparam int CNT_MAX = (MAX_LP > INIT_TIMEOUT) ? MAX_LP : INIT_TIMEOUT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int SYNC_N  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] POWERUP_LAST = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] INIT_LAST    = CNT_W'(INIT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    LOCK_QUAL = 3'd1,
    POWERUP   = 3'd2,
    INIT      = 3'd3,
    READY     = 3'd4,
    FAULT     = 3'd5
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [SYNC_N-1:0] sync_reg;
  logic              lock_s;

  // pll_lock is asynchronous to clk; this chain is its only consumer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_reg <= '0;
    else     sync_reg <= {sync_reg[SYNC_N-2:0], pll_lock};
  end

  assign lock_s = sync_reg[SYNC_N-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= WAIT_LOCK;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    // Loss of lock outranks everything, including a simultaneous init_ack
    if (state_reg != WAIT_LOCK && !lock_s) begin
      state_next = WAIT_LOCK;
      cnt_next   = '0;
    end else begin
      unique case (state_reg)
        WAIT_LOCK: begin
          cnt_next = '0;
          if (lock_s) state_next = LOCK_QUAL;
        end
        LOCK_QUAL: begin
          if (cnt_reg == LOCK_LAST) begin
            state_next = POWERUP;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        POWERUP: begin
          if (cnt_reg == POWERUP_LAST) begin
            state_next = INIT;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        INIT: begin
          if (init_ack) begin
            state_next = READY;
            cnt_next   = '0;
          end else if (cnt_reg == INIT_LAST) begin
            state_next = FAULT;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        READY, FAULT: begin
          state_next = state_reg;
        end
        default: begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    ctrl_reset = 1'b0;
    init_req   = 1'b0;
    ready      = 1'b0;
    fault      = 1'b0;
    unique case (state_reg)
      WAIT_LOCK, LOCK_QUAL: ctrl_reset = 1'b1;
      INIT:                 init_req   = 1'b1;
      READY:                ready      = 1'b1;
      FAULT:                fault      = 1'b1;
      default:              ctrl_reset = (state_reg != POWERUP);
    endcase
  end

  assign state = state_reg;

endmodule

// File: tb/tb_psram_clk_reset_seq.sv
// Scoreboard bench for psram_clk_reset_seq: two instances (long and short init
// timeout) with expected outputs queued per edge and compared as edges occur.
`timescale 1ns/1ps
module tb_psram_clk_reset_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, lock_a, ack_a, rst_b, lock_b, ack_b;
  logic       cr_a, ir_a, rd_a, ft_a, cr_b, ir_b, rd_b, ft_b;
  logic [2:0] st_a, st_b;

  psram_clk_reset_seq #(.LOCK_STABLE(16), .POWERUP_US(2), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst_a), .pll_lock(lock_a), .init_ack(ack_a),
    .ctrl_reset(cr_a), .init_req(ir_a), .ready(rd_a), .fault(ft_a), .state(st_a));

  psram_clk_reset_seq #(.LOCK_STABLE(16), .POWERUP_US(2), .SYNC_STAGES(2), .INIT_TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst_b), .pll_lock(lock_b), .init_ack(ack_b),
    .ctrl_reset(cr_b), .init_req(ir_b), .ready(rd_b), .fault(ft_b), .state(st_b));

  // {state, ctrl_reset, init_req, ready, fault}
  localparam logic [6:0] WL = 7'b000_1000;
  localparam logic [6:0] LQ = 7'b001_1000;
  localparam logic [6:0] PU = 7'b010_0000;
  localparam logic [6:0] IN = 7'b011_0100;
  localparam logic [6:0] RD = 7'b100_0010;
  localparam logic [6:0] FT = 7'b101_0001;

  logic [6:0] obs_a, obs_b;
  assign obs_a = {st_a, cr_a, ir_a, rd_a, ft_a};
  assign obs_b = {st_b, cr_b, ir_b, rd_b, ft_b};

  typedef struct {
    int         e;
    bit         b;
    logic [6:0] v;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   e;

  function automatic void push(int ed, bit b, logic [6:0] v);
    exp_t x;
    x.e = ed; x.b = b; x.v = v;
    q.push_back(x);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic test_reset();
    exp_t x;
    rst_a = 1'b1; rst_b = 1'b1; lock_a = 1'b0; lock_b = 1'b0; ack_a = 1'b0; ack_b = 1'b0;
    e = 0;
    push(0, 1'b0, WL);
    push(0, 1'b1, WL);
    repeat (3) tick();
    while (q.size() > 0) begin
      x = q.pop_front();
      checks++;
      if ((x.b ? obs_b : obs_a) !== x.v) begin
        failures++;
        $display("FAIL reset dut%0d got=%b want=%b", x.b, x.b ? obs_b : obs_a, x.v);
      end
    end
    rst_a = 1'b0; rst_b = 1'b0;
  endtask

  task automatic test_nominal();
    exp_t x;
    push(0, 0, WL); push(1, 0, WL); push(2, 0, LQ); push(17, 0, LQ); push(18, 0, PU);
    push(179, 0, PU); push(180, 0, IN); push(189, 0, IN); push(190, 0, RD); push(200, 0, RD);
    e = -1;
    lock_a = 1'b1;
    for (int i = 0; i <= 200; i++) begin
      ack_a = (e + 1 == 190);
      tick();
      while (q.size() > 0 && q[0].e == e) begin
        x = q.pop_front();
        checks++;
        if (obs_a !== x.v) begin
          failures++;
          $display("FAIL nominal edge=%0d got=%b want=%b", e, obs_a, x.v);
        end
      end
    end
    ack_a = 1'b0;
  endtask

  task automatic test_lock_loss_ready();
    exp_t x;
    push(0, 0, RD); push(1, 0, RD); push(2, 0, WL); push(10, 0, WL);
    e = -1;
    lock_a = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      tick();
      while (q.size() > 0 && q[0].e == e) begin
        x = q.pop_front();
        checks++;
        if (obs_a !== x.v) begin
          failures++;
          $display("FAIL lock_loss edge=%0d got=%b want=%b", e, obs_a, x.v);
        end
      end
    end
    push(1, 0, WL); push(2, 0, LQ); push(17, 0, LQ); push(18, 0, PU);
    push(180, 0, IN); push(185, 0, RD);
    e = -1;
    lock_a = 1'b1;
    for (int i = 0; i <= 186; i++) begin
      ack_a = (e + 1 == 185);
      tick();
      while (q.size() > 0 && q[0].e == e) begin
        x = q.pop_front();
        checks++;
        if (obs_a !== x.v) begin
          failures++;
          $display("FAIL relock edge=%0d got=%b want=%b", e, obs_a, x.v);
        end
      end
    end
    ack_a = 1'b0;
  endtask

  task automatic test_lock_glitch();
    exp_t x;
    lock_a = 1'b0;
    rst_a  = 1'b1;
    tick();
    rst_a = 1'b0;
    push(9, 0, LQ); push(11, 0, LQ); push(12, 0, WL); push(13, 0, WL); push(14, 0, WL);
    push(15, 0, LQ); push(30, 0, LQ); push(31, 0, PU); push(50, 0, PU);
    e = -1;
    for (int i = 0; i <= 50; i++) begin
      lock_a = !((e + 1 >= 10) && (e + 1 <= 12));
      tick();
      while (q.size() > 0 && q[0].e == e) begin
        x = q.pop_front();
        checks++;
        if (obs_a !== x.v) begin
          failures++;
          $display("FAIL glitch edge=%0d got=%b want=%b", e, obs_a, x.v);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t x;
    time t0;
    // dut_a is mid-POWERUP here with lock still high
    #2;
    t0 = $time;
    rst_a = 1'b1;
    #1;
    checks++;
    if (obs_a !== WL || $time - t0 != 1) begin
      failures++;
      $display("FAIL async_reset got=%b want=%b", obs_a, WL);
    end
    #2;
    rst_a = 1'b0;
    push(0, 0, WL); push(1, 0, WL); push(2, 0, LQ); push(17, 0, LQ); push(18, 0, PU);
    e = -1;
    for (int i = 0; i <= 18; i++) begin
      tick();
      while (q.size() > 0 && q[0].e == e) begin
        x = q.pop_front();
        checks++;
        if (obs_a !== x.v) begin
          failures++;
          $display("FAIL after_reset edge=%0d got=%b want=%b", e, obs_a, x.v);
        end
      end
    end
  endtask

  task automatic test_init_timeout();
    exp_t x;
    push(179, 1, PU); push(180, 1, IN); push(187, 1, IN); push(188, 1, FT);
    push(196, 1, FT); push(200, 1, FT);
    e = -1;
    lock_b = 1'b1;
    for (int i = 0; i <= 200; i++) begin
      ack_b = (e + 1 == 195);
      tick();
      while (q.size() > 0 && q[0].e == e) begin
        x = q.pop_front();
        checks++;
        if (obs_b !== x.v) begin
          failures++;
          $display("FAIL timeout edge=%0d got=%b want=%b", e, obs_b, x.v);
        end
      end
    end
    ack_b = 1'b0;
  endtask

  task automatic test_ack_collision();
    exp_t x;
    lock_b = 1'b0;
    rst_b  = 1'b1;
    tick();
    rst_b = 1'b0;
    push(110, 1, PU); push(111, 1, PU); push(187, 1, IN); push(188, 1, RD); push(195, 1, RD);
    e = -1;
    lock_b = 1'b1;
    for (int i = 0; i <= 195; i++) begin
      ack_b = ((e + 1 >= 100) && (e + 1 <= 110)) || (e + 1 == 188);
      tick();
      while (q.size() > 0 && q[0].e == e) begin
        x = q.pop_front();
        checks++;
        if (obs_b !== x.v) begin
          failures++;
          $display("FAIL collision edge=%0d got=%b want=%b", e, obs_b, x.v);
        end
      end
    end
    ack_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lock_loss_ready();
    test_lock_glitch();
    test_async_reset();
    test_init_timeout();
    test_ack_collision();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
